// File: rtl/speed_pkg.sv
// -----------------------------------------------------------------------------
// speed_pkg
// Shared definitions for the speed integrator and anything that talks to it.
//   state_t    : integrator FSM states (IDLE, ACCEL, COAST, BRAKE)
//   ACC_*      : encodings of the 2-bit accel command from the key compiler
//   DIST_W     : width of the wrapping distance accumulator
//   cmd_target : maps a raw accel command onto the state it requests
// -----------------------------------------------------------------------------
package speed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCEL = 2'd1,
        COAST = 2'd2,
        BRAKE = 2'd3
    } state_t;

    localparam logic [1:0] ACC_NONE  = 2'b00;
    localparam logic [1:0] ACC_BRAKE = 2'b01;
    localparam logic [1:0] ACC_GO    = 2'b10;

    localparam int DIST_W = 16;

    // Both pedals at once (2'b11) is treated as braking, so braking wins
    // whenever the brake bit is set.
    function automatic state_t cmd_target(input logic [1:0] cmd);
        state_t target;
        case (cmd)
            ACC_NONE:  target = COAST;
            ACC_GO:    target = ACCEL;
            ACC_BRAKE: target = BRAKE;
            default:   target = BRAKE;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/speed_integrator_if.sv
// -----------------------------------------------------------------------------
// speed_integrator_if
// Bundles the command input and the status outputs of the speed integrator.
//   accel     : 2-bit command from the key compiler
//   speed     : current speed (SPEED_W bits)
//   distance  : wrapping running sum of speed (DIST_W bits)
//   tick      : one-cycle pulse on each update
//   moving    : speed is nonzero
//   at_max    : speed sits at the ceiling
//   dist_wrap : one-cycle pulse when distance overflowed on the last update
// master is the side that issues commands and consumes status (key compiler /
// game logic); slave is the integrator itself.
// SPEED_W must match the SPEED_W of the integrator it is connected to.
// -----------------------------------------------------------------------------
interface speed_integrator_if
    import speed_pkg::*;
#(
    parameter int SPEED_W = 8
) ();

    logic [1:0]         accel;
    logic [SPEED_W-1:0] speed;
    logic [DIST_W-1:0]  distance;
    logic               tick;
    logic               moving;
    logic               at_max;
    logic               dist_wrap;

    modport master (
        output accel,
        input  speed,
        input  distance,
        input  tick,
        input  moving,
        input  at_max,
        input  dist_wrap
    );

    modport slave (
        input  accel,
        output speed,
        output distance,
        output tick,
        output moving,
        output at_max,
        output dist_wrap
    );

endinterface

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running divider that produces a one-cycle pulse every TICK_DIV clocks.
// Reusable by any game block that needs a slower update rate.
//   CLOCK_50 : clock
//   reset    : synchronous, active-high; restarts the count at 0
//   tick     : high for the single cycle in which the count equals TICK_DIV-1
// TICK_DIV must be at least 2.
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..TICK_DIV-1 and wrap. Because tick is decoded from the count,
    // a reset leaves the first pulse a full TICK_DIV cycles away.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/speed_integrator.sv
// -----------------------------------------------------------------------------
// speed_integrator
// Integrates the accel command from the key compiler into a saturating speed
// on every update tick, applies a slow drag while coasting and accumulates a
// wrapping distance counter for the game/display logic.
//   CLOCK_50 : clock
//   reset    : synchronous, active-high; clears every register and the divider
//   bus      : slave side of speed_integrator_if (accel in; speed, distance,
//              tick, moving, at_max, dist_wrap out)
// All registered outputs change on the edge that ends the tick cycle, so they
// are visible the cycle after tick is high.
// -----------------------------------------------------------------------------
module speed_integrator
    import speed_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int SPEED_W    = 8,
    parameter int MAX_SPEED  = 200,
    parameter int ACCEL_STEP = 2,
    parameter int BRAKE_STEP = 4,
    parameter int DRAG_STEP  = 1,
    parameter int DRAG_DIV   = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    speed_integrator_if.slave bus
);

    // Speed constants held one bit wider than speed so sums and comparisons
    // cannot overflow.
    localparam logic [SPEED_W:0] MAX_W   = (SPEED_W + 1)'(MAX_SPEED);
    localparam logic [SPEED_W:0] ACCEL_W = (SPEED_W + 1)'(ACCEL_STEP);
    localparam logic [SPEED_W:0] BRAKE_W = (SPEED_W + 1)'(BRAKE_STEP);
    localparam logic [SPEED_W:0] DRAG_W  = (SPEED_W + 1)'(DRAG_STEP);

    localparam int                 DRAG_CW   = (DRAG_DIV > 1) ? $clog2(DRAG_DIV) : 1;
    localparam logic [DRAG_CW-1:0] DRAG_LAST = DRAG_CW'(DRAG_DIV - 1);

    logic                tick;
    state_t              state_q, state_d;
    state_t              target;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [SPEED_W:0]    accel_sum;
    logic [SPEED_W:0]    speed_wide;
    logic [SPEED_W-1:0]  accel_val, brake_val, drag_val;
    logic [DRAG_CW-1:0]  drag_q, drag_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic [DIST_W:0]     dist_sum;
    logic                wrap_q, wrap_d;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick)
    );

    // Candidate next speeds for each command, all saturating. They are
    // computed every cycle and only one is picked on the tick cycle.
    always_comb begin
        speed_wide = {1'b0, speed_q};
        accel_sum  = speed_wide + ACCEL_W;
        accel_val  = (accel_sum > MAX_W) ? MAX_W[SPEED_W-1:0] : accel_sum[SPEED_W-1:0];
        brake_val  = (speed_wide > BRAKE_W) ? speed_q - BRAKE_W[SPEED_W-1:0] : '0;
        drag_val   = (speed_wide > DRAG_W) ? speed_q - DRAG_W[SPEED_W-1:0] : '0;
        dist_sum   = {1'b0, dist_q} + {{(DIST_W + 1 - SPEED_W){1'b0}}, speed_q};
        target     = cmd_target(bus.accel);
    end

    // Next-state logic. Nothing moves except on the tick cycle, which is also
    // the only cycle in which the command is looked at. The distance always
    // adds the speed from before this tick's update. The drag counter only
    // survives consecutive coasting ticks, so after a key is released the
    // first drag lands DRAG_DIV ticks later, and the tick on which a new
    // command arrives never drags.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        drag_d  = drag_q;
        dist_d  = dist_q;
        wrap_d  = 1'b0;
        if (tick) begin
            {wrap_d, dist_d} = dist_sum;
            case (target)
                ACCEL: begin
                    speed_d = accel_val;
                    drag_d  = '0;
                    state_d = ACCEL;
                end
                BRAKE: begin
                    speed_d = brake_val;
                    drag_d  = '0;
                    state_d = (brake_val == '0) ? IDLE : BRAKE;
                end
                default: begin
                    if (speed_q == '0) begin
                        drag_d  = '0;
                        state_d = IDLE;
                    end else if (drag_q == DRAG_LAST) begin
                        speed_d = drag_val;
                        drag_d  = '0;
                        state_d = (drag_val == '0) ? IDLE : COAST;
                    end else begin
                        drag_d  = drag_q + DRAG_CW'(1);
                        state_d = COAST;
                    end
                end
            endcase
        end
    end

    // State and datapath registers. Reset wins even on a tick cycle, so no
    // update is ever applied in the same cycle as reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            speed_q <= '0;
            drag_q  <= '0;
            dist_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            drag_q  <= drag_d;
            dist_q  <= dist_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.speed     = speed_q;
    assign bus.distance  = dist_q;
    assign bus.tick      = tick;
    assign bus.moving    = (speed_q != '0);
    assign bus.at_max    = (speed_q == MAX_W[SPEED_W-1:0]);
    assign bus.dist_wrap = wrap_q;

endmodule
